// File: rtl/bayer_linebuf_pkg.sv
// bayer_linebuf_pkg
//   Shared types and sizing helpers for the Bayer three-row line buffer.
//   - state_e     : frame-level state of the line buffer controller.
//   - tap_ctl_t   : sideband that travels alongside the RAM read so the
//                   output register knows what to emit.
//   - col_w/row_w : counter widths derived from the image geometry.
//   - COL_W/ROW_W : widths for the default 640x480 geometry.
package bayer_linebuf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  // Control bits that ride one stage behind the accepted beat, aligned
  // with the registered RAM read data.
  typedef struct packed {
    logic valid;     // an output column is produced next cycle
    logic user;      // first column of the first emitted row
    logic last;      // last column of an emitted row
    logic zero_top;  // top tap has no row above it (row 1)
    logic zero_bot;  // bottom tap has no row below it (flush)
  } tap_ctl_t;

  function automatic int col_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int row_w(input int height);
    return (height > 0) ? $clog2(height + 1) : 1;
  endfunction

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int COL_W = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_W = $clog2(DEF_IMG_HEIGHT + 1);

endpackage

// File: rtl/bayer_linebuf3_ram.sv
// line_buffer_ram
//   Simple dual-port RAM, one write port and one registered read port.
//   A read and a write to the same address in one cycle return the old
//   contents (read-first).
//   Ports:
//     clk_i   : clock
//     we_i    : write enable      waddr_i / wdata_i : write address / data
//     re_i    : read enable       raddr_i           : read address
//     rdata_o : registered read data, valid the cycle after re_i
module line_buffer_ram
  import bayer_linebuf_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 10,
  parameter int AW    = col_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Non-blocking write and read in the same block give read-first
  // behaviour on an address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bayer_linebuf3.sv
// bayer_linebuf3
//   Converts a raster Bayer pixel stream into three vertically aligned row
//   taps (row r-1, r, r+1). Output row r is produced while input row r+1
//   arrives; the last row is produced by an internal flush after the final
//   input row, so every frame yields IMG_HEIGHT output rows.
//
//   Handshake: an input beat is accepted on a cycle where s_axis_tvalid and
//   s_axis_tready are both 1. The output side has no back-pressure; each
//   cycle with m_axis_tvalid=1 is one emitted tap column.
//
//   Ports:
//     pixel_clk, rst        : clock, synchronous active-high reset
//     s_axis_t*             : input pixel stream (tuser = start of frame,
//                             tlast = end of row)
//     m_axis_t*             : output framing for the tap columns
//     matrix_data01/11/21   : top / centre / bottom row taps
//     drop_err              : sticky, a beat was offered while not ready
//   Latency from accepted beat (or flush read) to output is 2 cycles.
module bayer_linebuf3
  import bayer_linebuf_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] matrix_data01,
  output logic [DATA_WIDTH-1:0] matrix_data11,
  output logic [DATA_WIDTH-1:0] matrix_data21,
  output logic                  drop_err
);

  localparam int CW = col_w(IMG_WIDTH);
  localparam int RW = row_w(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT);

  // Frame control state
  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            tready_q, tready_d;
  logic            drop_q, drop_d;

  // Stage aligned with the RAM read
  tap_ctl_t        ctl_q, ctl_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;

  // Deferred LB_A write (needs the old LB_B word, available after the read)
  logic            wa_we_q;
  logic [CW-1:0]   wa_addr_q;

  // Output registers
  logic            out_valid_q;
  logic            out_user_q;
  logic            out_last_q;
  logic [DATA_WIDTH-1:0] out_d01_q;
  logic [DATA_WIDTH-1:0] out_d11_q;
  logic [DATA_WIDTH-1:0] out_d21_q;

  // RAM control
  logic            beat;
  logic            lb_we;
  logic            ram_re;
  logic [CW-1:0]   addr;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == COL_LAST) ? c : c + CW'(1);
  endfunction

  assign beat = s_axis_tvalid & tready_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ctl_d   = '0;
    pix_d   = s_axis_tdata;
    addr    = col_q;
    lb_we   = 1'b0;
    ram_re  = 1'b0;

    case (state_q)
      IDLE, FILL, STREAM: begin
        if (beat) begin
          if (s_axis_tuser) begin
            // Start of frame from any accepting state: this beat is row 1,
            // column 0, and any partial frame is abandoned without flush.
            addr    = '0;
            lb_we   = 1'b1;
            ram_re  = 1'b1;
            state_d = s_axis_tlast ? STREAM : FILL;
            row_d   = s_axis_tlast ? ROW_TWO : ROW_ONE;
            col_d   = s_axis_tlast ? '0 : sat_inc('0);
          end else if (state_q != IDLE) begin
            lb_we  = 1'b1;
            ram_re = 1'b1;
            col_d  = s_axis_tlast ? '0 : sat_inc(col_q);
            if (state_q == STREAM) begin
              // row_q counts the input row, so the emitted row is row_q-1
              ctl_d.valid    = 1'b1;
              ctl_d.user     = (row_q == ROW_TWO) && (col_q == '0);
              ctl_d.last     = s_axis_tlast;
              ctl_d.zero_top = (row_q == ROW_TWO);
            end
            if (s_axis_tlast) begin
              row_d = row_q + RW'(1);
              if (state_q == FILL) begin
                state_d = STREAM;
              end else if (row_q == ROW_LAST) begin
                state_d = FLUSH;
              end
            end
          end
        end
      end
      FLUSH: begin
        // Emit the final row from the buffers, one column per clock.
        ram_re         = 1'b1;
        ctl_d.valid    = 1'b1;
        ctl_d.user     = (row_q == ROW_TWO) && (col_q == '0);
        ctl_d.last     = (col_q == COL_LAST);
        ctl_d.zero_top = (row_q == ROW_TWO);
        ctl_d.zero_bot = 1'b1;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = IDLE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    tready_d = (state_d != FLUSH);
    drop_d   = drop_q | (s_axis_tvalid & ~tready_q);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      tready_q    <= 1'b0;
      drop_q      <= 1'b0;
      ctl_q       <= '0;
      pix_q       <= '0;
      wa_we_q     <= 1'b0;
      wa_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_d01_q   <= '0;
      out_d11_q   <= '0;
      out_d21_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      tready_q    <= tready_d;
      drop_q      <= drop_d;
      ctl_q       <= ctl_d;
      pix_q       <= pix_d;
      wa_we_q     <= lb_we;
      wa_addr_q   <= addr;
      out_valid_q <= ctl_q.valid;
      out_user_q  <= ctl_q.valid & ctl_q.user;
      out_last_q  <= ctl_q.valid & ctl_q.last;
      // Data taps hold their value between emitted columns.
      if (ctl_q.valid) begin
        out_d01_q <= ctl_q.zero_top ? '0 : rd_a;
        out_d11_q <= rd_b;
        out_d21_q <= ctl_q.zero_bot ? '0 : pix_q;
      end
    end
  end

  // LB_A: row r-1. Written one cycle after the beat with the word LB_B held
  // at that column before the beat overwrote it.
  line_buffer_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH),
    .AW    (CW)
  ) u_lb_a (
    .clk_i   (pixel_clk),
    .we_i    (wa_we_q),
    .waddr_i (wa_addr_q),
    .wdata_i (rd_b),
    .re_i    (ram_re),
    .raddr_i (addr),
    .rdata_o (rd_a)
  );

  // LB_B: row r. Written with the incoming pixel on each frame beat.
  line_buffer_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH),
    .AW    (CW)
  ) u_lb_b (
    .clk_i   (pixel_clk),
    .we_i    (lb_we),
    .waddr_i (addr),
    .wdata_i (s_axis_tdata),
    .re_i    (ram_re),
    .raddr_i (addr),
    .rdata_o (rd_b)
  );

  assign s_axis_tready = tready_q;
  assign drop_err      = drop_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tlast  = out_last_q;
  assign matrix_data01 = out_d01_q;
  assign matrix_data11 = out_d11_q;
  assign matrix_data21 = out_d21_q;

endmodule

// File: tb/tb_bayer_linebuf3.sv
// tb_bayer_linebuf3
//   Directed bench for bayer_linebuf3 with an 8x4 image, pixel = row*16+col
//   (plus an optional base offset to tell frames apart). Every emitted tap
//   column is compared against an expected queue that also carries the
//   cycle at which the column must appear.
module tb_bayer_linebuf3;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 10;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tuser  = 1'b0;
  logic          s_tlast  = 1'b0;
  logic [DW-1:0] s_tdata  = '0;
  logic          m_tvalid;
  logic          m_tuser;
  logic          m_tlast;
  logic [DW-1:0] d01, d11, d21;
  logic          drop_err;

  bayer_linebuf3 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .pixel_clk     (clk),
    .rst           (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .matrix_data01 (d01),
    .matrix_data11 (d11),
    .matrix_data21 (d21),
    .drop_err      (drop_err)
  );

  // Scoreboard: {tuser, tlast, d01, d11, d21} plus expected output cycle
  int n_vec = 0;
  int n_err = 0;
  logic [2*1+3*DW-1:0] exp_q[$];
  int                  exp_cyc_q[$];
  logic [2*1+3*DW-1:0] mon_e;
  int                  mon_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int base, input int row, input int col);
    return DW'(base + row * 16 + col);
  endfunction

  function automatic logic [2*1+3*DW-1:0] mk(input logic u, input logic l,
      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    return {u, l, a, b, c};
  endfunction

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (m_tvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(m_tvalid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("out_taps", 64'({m_tuser, m_tlast, d01, d11, d21}), 64'(mon_e));
        check("out_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [DW-1:0] d, input logic u, input logic l, output int dc);
    @(posedge clk);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    dc       = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  // Sends ncols beats of one input row; queues the tap column each beat of
  // row k>=2 produces (row k-1), due 2 cycles after the beat.
  task automatic send_row(input int base, input int row, input int ncols,
      input bit gaps, input bit user_first, output int last_dc);
    int dc;
    for (int c = 0; c < ncols; c++) begin
      if (gaps) idle($urandom_range(0, 2));
      drive(pix(base, row, c), user_first && (c == 0), c == W - 1, dc);
      if (row >= 2) begin
        exp_q.push_back(mk((row == 2) && (c == 0), c == W - 1,
                           (row == 2) ? DW'(0) : pix(base, row - 2, c),
                           pix(base, row - 1, c), pix(base, row, c)));
        exp_cyc_q.push_back(dc + 2);
      end
      last_dc = dc;
    end
  endtask

  // Flush row H: first column appears 3 cycles after the final beat is driven.
  task automatic push_flush(input int base, input int last_dc);
    for (int c = 0; c < W; c++) begin
      exp_q.push_back(mk(1'b0, c == W - 1, pix(base, H - 1, c), pix(base, H, c), DW'(0)));
      exp_cyc_q.push_back(last_dc + 3 + c);
    end
  endtask

  task automatic send_frame(input int base, input bit gaps, output int last_dc);
    for (int r = 1; r <= H; r++) begin
      send_row(base, r, W, gaps, r == 1, last_dc);
    end
    push_flush(base, last_dc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, 64'(s_tready), 64'd0);
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_tuser"},  64'(m_tuser),  64'd0);
    check({tag, "_tlast"},  64'(m_tlast),  64'd0);
    check({tag, "_d01"},    64'(d01),      64'd0);
    check({tag, "_d11"},    64'(d11),      64'd0);
    check({tag, "_d21"},    64'(d21),      64'd0);
    check({tag, "_drop"},   64'(drop_err), 64'd0);
  endtask

  int ld;
  int dc;
  int low_cnt;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("tready_before_release", 64'(s_tready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("tready_after_release", 64'(s_tready), 64'd1);

    // Frame A: no gaps; tready must be low for exactly W cycles of flush
    send_frame(0, 1'b0, ld);
    idle(1);
    low_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_tready == 1'b0) low_cnt++;
    end
    check("tready_low_cycles", 64'(low_cnt), 64'(W));
    check("drop_clean", 64'(drop_err), 64'd0);

    // Frame B: random gaps, then a beat offered during flush
    send_frame(0, 1'b1, ld);
    idle(1);
    drive(DW'(10'h3FF), 1'b0, 1'b0, dc);
    idle(1);
    @(negedge clk);
    check("drop_set", 64'(drop_err), 64'd1);
    idle(15);
    @(negedge clk);
    check("drop_sticky", 64'(drop_err), 64'd1);

    // Reset clears the sticky flag
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("drop_cleared", 64'(drop_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Mid-frame tuser during row 3: old frame abandoned without flush
    send_row(12'h200, 1, W, 1'b0, 1'b1, ld);
    send_row(12'h200, 2, W, 1'b0, 1'b0, ld);
    send_row(12'h200, 3, 4, 1'b0, 1'b0, ld);
    send_frame(0, 1'b0, ld);
    idle(20);

    // Reset mid-STREAM clears every output on the next cycle
    send_row(0, 1, W, 1'b0, 1'b1, ld);
    send_row(0, 2, 4, 1'b0, 1'b0, ld);
    idle(3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Beats before tuser are ignored, then a clean frame
    drive(DW'(10'h155), 1'b0, 1'b0, dc);
    drive(DW'(10'h0AA), 1'b0, 1'b0, dc);
    drive(DW'(10'h0F0), 1'b0, 1'b1, dc);
    idle(2);
    send_frame(0, 1'b0, ld);
    idle(1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("drop_final", 64'(drop_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bayer_linebuf3.md
Name: bayer_linebuf3

Overview:
- Upstream neighbour of the Bayer demosaic stage. Turns a raster Bayer pixel stream (one pixel per clock, AXI-stream-like sideband) into three vertically aligned row taps: row r-1, row r and row r+1.
- Output row r is emitted while input row r+1 arrives. After the last input row, the block generates the final output row itself (flush).
- It therefore emits IMG_HEIGHT rows per frame, each with correct tuser/tlast framing.

Parameters:
- DATA_WIDTH, 10, bits per Bayer pixel.
- IMG_WIDTH, 640, pixels per row; this is the line-buffer depth.
- IMG_HEIGHT, 480, rows per frame.

Ports:
- pixel_clk, in, 1, the single clock.
- rst, in, 1, synchronous, active-high reset.
- s_axis_tvalid, in, 1, input pixel valid.
- s_axis_tready, out, 1, input accept; low during reset and during FLUSH.
- s_axis_tuser, in, 1, start of frame, on the first pixel of row 1.
- s_axis_tlast, in, 1, end of row.
- s_axis_tdata, in, DATA_WIDTH, Bayer pixel.
- m_axis_tvalid, out, 1, output tap column valid.
- m_axis_tuser, out, 1, first pixel of the first emitted row.
- m_axis_tlast, out, 1, last pixel of each emitted row.
- matrix_data01, out, DATA_WIDTH, row r-1 pixel (top).
- matrix_data11, out, DATA_WIDTH, row r pixel (centre).
- matrix_data21, out, DATA_WIDTH, row r+1 pixel (bottom).
- drop_err, out, 1, sticky flag: a beat was offered while s_axis_tready=0. Cleared only by rst.

Behaviour:
- Beat definition: a beat is accepted when s_axis_tvalid and s_axis_tready are both 1.
- Reset:
  - All outputs are 0, including s_axis_tready and drop_err.
  - State is IDLE; column and row counters are 0.
  - s_axis_tready goes to 1 on the first cycle after rst deasserts.
  - rst mid-frame abandons the frame, with no further output. RAM contents are don't-care.
- Line buffers:
  - LB_A holds row r-1 and LB_B holds row r. Both are read-first, depth IMG_WIDTH, addressed by the column counter.
  - On each beat at column c: read LB_A[c] and LB_B[c], then write LB_A[c] with the old LB_B[c] and LB_B[c] with s_axis_tdata.
- Column counter:
  - Increments per beat and resets to 0 on a tlast beat.
  - Saturates at IMG_WIDTH-1. Beats past saturation overwrite that address.
- Row counter: increments on each tlast beat.
- State machine:
  - IDLE: beats without tuser are discarded. A tuser beat enters FILL, is written as row 1, column 0, and sets the row counter to 1.
  - FILL: row 1 is written into LB_B with no output. A tlast beat enters STREAM.
  - STREAM: each beat of input row r+1 outputs one column of row r.
    - matrix_data01 = LB_A read, or 0 when r=1.
    - matrix_data11 = LB_B read.
    - matrix_data21 = input pixel, delayed to match the RAM read.
    - The tlast beat of input row IMG_HEIGHT enters FLUSH.
  - FLUSH: s_axis_tready=0. The block emits IMG_WIDTH consecutive valid columns of row IMG_HEIGHT.
    - matrix_data01 = LB_A, matrix_data11 = LB_B, matrix_data21 = 0.
    - Columns are emitted one per clock, starting the cycle after entry.
    - After column IMG_WIDTH-1 is read, the block returns to IDLE.
- Latency: the outputs for an input beat (or a FLUSH read) appear exactly 2 cycles later. This is the RAM read plus the output register.
- Framing:
  - m_axis_tvalid=1 only for emitted columns.
  - m_axis_tuser=1 only at row 1, column 0 output.
  - m_axis_tlast=1 at output column IMG_WIDTH-1 of every emitted row; in STREAM it follows the input tlast.
  - When m_axis_tvalid=0, the data outputs hold their last value.
- Mid-frame tuser: a tuser beat in FILL or STREAM restarts the frame. That beat becomes row 1, column 0, the state becomes FILL, and the partial frame is not flushed.
- drop_err is set when s_axis_tvalid=1 and s_axis_tready=0. The offered pixel is discarded.
- Frame gaps: idle cycles with tvalid=0 are allowed anywhere. Output pauses 1:1 with input in STREAM; FLUSH never pauses.

Decomposition:
- Package bayer_linebuf_pkg:
  - State enum IDLE/FILL/STREAM/FLUSH.
  - COL_W = clog2(IMG_WIDTH) and ROW_W = clog2(IMG_HEIGHT+1).
- Sub-module line_buffer_ram: simple dual-port, read-first, registered read, depth and width parameterised. It is instantiated twice (LB_A, LB_B).

Test Plan (W=8, H=4, DATA_WIDTH=10, pixel = row*16+col):
- Full frame with no gaps:
  - Input 4x8 beats → 32 output columns.
  - Row 1 has d01=0, d11=0x10+c, d21=0x20+c.
  - Row 4 (flush) has d01=0x30+c, d11=0x40+c, d21=0.
  - tuser only on the first output; tlast at c=7 of each row; tready low for exactly 8 cycles.
- Latency: the first STREAM beat (row 2, column 0) at cycle t → m_axis_tvalid with d11=0x10 at cycle t+2.
- Random tvalid gaps in STREAM → identical output data sequence, with each output 2 cycles after its input beat.
- Beat offered during FLUSH → drop_err=1 and held until rst; pixel discarded; flush data unchanged.
- tuser during row 3 → no flush of the old frame; new row 1 taps are correct when the new row 2 arrives.
- rst asserted mid-STREAM → next cycle all outputs 0; frame abandoned; a new frame after release outputs correctly; beats before tuser are ignored.
